// File: rtl/t05_spi_rx_packer.sv
// SPI read-byte packer: groups of four bytes become little-endian 32-bit words,
// buffered in a first-word-fall-through FIFO with read_stop backpressure.
module t05_spi_rx_packer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned STOP_MARGIN = 2
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         clear,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  input  logic                         read_done,
  output logic [31:0]                  word_out,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         read_stop,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [1:0]                   partial_bytes,
  output logic                         overflow
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   pack_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0]   lane_word;
  logic [31:0]   push_word;
  logic [2:0]    cnt_after;
  logic          complete;
  logic          flush;
  logic          push;
  logic          pop;
  logic          accept;

  // Packer next value, flush/completion detection and FIFO push/pop decisions.
  always_comb begin
    lane_word = pack_q;
    push_word = '0;
    cnt_after = 3'(partial_bytes) + 3'(byte_valid);
    for (int i = 0; i < 4; i++) begin
      if (byte_valid && (partial_bytes == 2'(i))) begin
        lane_word[8*i +: 8] = byte_in;
      end
    end
    // Lanes not yet filled are forced to zero so flushed words are padded.
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < cnt_after) begin
        push_word[8*i +: 8] = lane_word[8*i +: 8];
      end
    end
    complete = byte_valid && (partial_bytes == 2'd3);
    flush    = read_done && (cnt_after != 3'd0);
    push     = !clear && (complete || flush);
    pop      = !clear && word_valid && word_ready;
    accept   = push && ((level < LW'(DEPTH)) || pop);
  end

  assign word_valid = (level != '0);
  assign word_out   = word_valid ? mem[rd_ptr] : '0;
  assign read_stop  = (level >= LW'(DEPTH - STOP_MARGIN));

  // Control state: packer, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pack_q        <= '0;
      partial_bytes <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      overflow      <= 1'b0;
    end else if (clear) begin
      pack_q        <= '0;
      partial_bytes <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      overflow      <= 1'b0;
    end else begin
      if (byte_valid) begin
        pack_q <= lane_word;
      end
      if (push) begin
        partial_bytes <= '0;
      end else if (byte_valid) begin
        partial_bytes <= partial_bytes + 2'd1;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level <= level + LW'(accept) - LW'(pop);
      if (push && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage has no reset; word_out is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= push_word;
    end
  end

endmodule

// File: tb/tb_t05_spi_rx_packer.sv
// Directed bench for t05_spi_rx_packer with hand-computed expected values.
module tb_t05_spi_rx_packer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        clear;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        read_done;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        read_stop;
  logic [3:0]  level;
  logic [1:0]  partial_bytes;
  logic        overflow;

  int n_total  = 0;
  int n_passed = 0;

  t05_spi_rx_packer #(.DEPTH(8), .STOP_MARGIN(2)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .clear         (clear),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .read_done     (read_done),
    .word_out      (word_out),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .read_stop     (read_stop),
    .level         (level),
    .partial_bytes (partial_bytes),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b, input logic done, input logic rdy);
    byte_in    = b;
    byte_valid = 1'b1;
    read_done  = done;
    word_ready = rdy;
    tick();
    byte_valid = 1'b0;
    read_done  = 1'b0;
    word_ready = 1'b0;
  endtask

  task automatic push_w(input logic [31:0] w);
    for (int i = 0; i < 4; i++) strobe(w[8*i +: 8], 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  function automatic logic [31:0] fill_word(input int i);
    return 32'(i) * 32'h0101_0101 + 32'h0010_2030;
  endfunction

  initial begin
    nrst = 1'b0; clear = 1'b0; byte_in = '0; byte_valid = 1'b0;
    read_done = 1'b0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",   32'(word_valid), 32'd0);
    check("rst_word",    word_out,        32'd0);
    check("rst_level",   32'(level),      32'd0);
    check("rst_partial", 32'(partial_bytes), 32'd0);
    check("rst_stop",    32'(read_stop),  32'd0);
    check("rst_ovf",     32'(overflow),   32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Basic four-byte word
    strobe(8'h11, 1'b0, 1'b0);
    strobe(8'h22, 1'b0, 1'b0);
    check("pack_partial2", 32'(partial_bytes), 32'd2);
    check("pack_notvalid", 32'(word_valid), 32'd0);
    strobe(8'h33, 1'b0, 1'b0);
    strobe(8'h44, 1'b0, 1'b0);
    check("word1_valid",   32'(word_valid), 32'd1);
    check("word1_data",    word_out, 32'h4433_2211);
    check("word1_level",   32'(level), 32'd1);
    check("word1_partial", 32'(partial_bytes), 32'd0);
    pop_one();
    check("pop_level", 32'(level), 32'd0);

    // Partial flush and empty read_done
    strobe(8'hAA, 1'b0, 1'b0);
    strobe(8'hBB, 1'b0, 1'b0);
    read_done = 1'b1; tick(); read_done = 1'b0;
    check("flush_data",    word_out, 32'h0000_BBAA);
    check("flush_level",   32'(level), 32'd1);
    check("flush_partial", 32'(partial_bytes), 32'd0);
    read_done = 1'b1; tick(); read_done = 1'b0;
    check("empty_done_level", 32'(level), 32'd1);
    pop_one();

    // Fill towards full, backpressure and overflow
    for (int i = 1; i <= 5; i++) push_w(fill_word(i));
    check("lvl5_stop", 32'(read_stop), 32'd0);
    push_w(fill_word(6));
    check("lvl6_stop",  32'(read_stop), 32'd1);
    check("lvl6_level", 32'(level), 32'd6);
    push_w(fill_word(7));
    push_w(fill_word(8));
    check("full_level", 32'(level), 32'd8);
    check("full_ovf",   32'(overflow), 32'd0);
    push_w(32'hDEAD_BEEF);
    check("drop_level",   32'(level), 32'd8);
    check("drop_ovf",     32'(overflow), 32'd1);
    check("drop_partial", 32'(partial_bytes), 32'd0);
    check("drop_head",    word_out, fill_word(1));
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr1_ovf", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous pop and push
    for (int i = 1; i <= 8; i++) push_w(fill_word(i));
    strobe(8'h91, 1'b0, 1'b0);
    strobe(8'h92, 1'b0, 1'b0);
    strobe(8'h93, 1'b0, 1'b0);
    strobe(8'h94, 1'b0, 1'b1);
    check("pp_level", 32'(level), 32'd8);
    check("pp_ovf",   32'(overflow), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("drain%0d", i), word_out, fill_word(i));
      pop_one();
    end
    check("drain_last", word_out, 32'h9493_9291);
    pop_one();
    check("drain_empty", 32'(word_valid), 32'd0);

    // Fourth byte together with read_done: single push
    strobe(8'h01, 1'b0, 1'b0);
    strobe(8'h02, 1'b0, 1'b0);
    strobe(8'h03, 1'b0, 1'b0);
    strobe(8'h55, 1'b1, 1'b0);
    check("combo_data",  word_out, 32'h5503_0201);
    check("combo_level", 32'(level), 32'd1);
    tick();
    check("combo_level_hold", 32'(level), 32'd1);

    // Synchronous clear with level 3, partial 2, overflow set
    for (int i = 1; i <= 7; i++) push_w(fill_word(i));
    push_w(32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) pop_one();
    strobe(8'h66, 1'b0, 1'b0);
    strobe(8'h77, 1'b0, 1'b0);
    check("preclr_level",   32'(level), 32'd3);
    check("preclr_partial", 32'(partial_bytes), 32'd2);
    check("preclr_ovf",     32'(overflow), 32'd1);
    clear = 1'b1; byte_valid = 1'b1; byte_in = 8'h88;
    tick();
    clear = 1'b0; byte_valid = 1'b0;
    check("clr_level",   32'(level), 32'd0);
    check("clr_partial", 32'(partial_bytes), 32'd0);
    check("clr_ovf",     32'(overflow), 32'd0);
    check("clr_valid",   32'(word_valid), 32'd0);
    check("clr_word",    word_out, 32'd0);
    check("clr_stop",    32'(read_stop), 32'd0);

    // Asynchronous reset mid-word
    push_w(32'h1234_5678);
    strobe(8'hEE, 1'b0, 1'b0);
    nrst = 1'b0;
    #1;
    check("arst_level",   32'(level), 32'd0);
    check("arst_partial", 32'(partial_bytes), 32'd0);
    check("arst_valid",   32'(word_valid), 32'd0);
    check("arst_word",    word_out, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    push_w(32'hA4A3_A2A1);
    check("post_rst_data",  word_out, 32'hA4A3_A2A1);
    check("post_rst_level", 32'(level), 32'd1);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
